pulse_accumulator: RTL



---
 rtl/pulse_accumulator.sv | 115 +++++++++++
 1 files changed

// File: rtl/pulse_accumulator.sv
// Saturating pulse counter with a threshold event and a read port that clears the count on each handshake.
// Define PULSE_ACCUMULATOR_DROP_COUNTER_EN to add dropped_count, which counts pulses discarded while saturated.
module pulse_accumulator #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pulse_in,
  input  logic [COUNT_WIDTH-1:0] threshold,
  output logic                   read_valid,
  input  logic                   read_ready,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic                   threshold_pulse,
  output logic                   overflow
`ifdef PULSE_ACCUMULATOR_DROP_COUNTER_EN
  ,
  output logic [COUNT_WIDTH-1:0] dropped_count
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACCUM,
    ST_SAT
  } state_e;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   thr_pulse_q, thr_pulse_d;
  logic                   valid_w;
  logic                   handshake;
  logic                   incremented;
  state_e                 state;

  // The state is a decode of the count register rather than separate flops, so it cannot disagree with the count.
  always_comb begin
    if (count_q == CNT_MAX) begin
      state = ST_SAT;
    end else if (count_q != CNT_ZERO) begin
      state = ST_ACCUM;
    end else begin
      state = ST_EMPTY;
    end
  end

  assign valid_w   = (count_q != CNT_ZERO) | overflow_q;
  assign handshake = valid_w & read_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= CNT_ZERO;
      overflow_q  <= 1'b0;
      thr_pulse_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      thr_pulse_q <= thr_pulse_d;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    incremented = 1'b0;
    if (handshake) begin
      // A pulse that coincides with a read is absorbed as the first event of the next batch.
      count_d     = {{(COUNT_WIDTH-1){1'b0}}, pulse_in};
      overflow_d  = 1'b0;
      incremented = pulse_in;
    end else if (pulse_in) begin
      case (state)
        ST_SAT: overflow_d = 1'b1;
        default: begin
          count_d     = count_q + 1'b1;
          incremented = 1'b1;
        end
      endcase
    end
    thr_pulse_d = incremented && (threshold != CNT_ZERO) && (count_d == threshold);
  end

  always_comb begin
    read_valid      = valid_w;
    read_count      = count_q;
    threshold_pulse = thr_pulse_q;
    overflow        = overflow_q;
  end

`ifdef PULSE_ACCUMULATOR_DROP_COUNTER_EN
  logic [COUNT_WIDTH-1:0] dropped_q, dropped_d;

  always_comb begin
    dropped_d = dropped_q;
    if (handshake) begin
      dropped_d = CNT_ZERO;
    end else if (pulse_in && (state == ST_SAT) && (dropped_q != CNT_MAX)) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped_q <= CNT_ZERO;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign dropped_count = dropped_q;
`endif

endmodule
